// File: rtl/axi_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_read_arbiter: shares one AXI3 AR/R channel pair between icache fill, |
// | dcache fill and uncached reads, one transaction at a time.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module axi_read_arbiter #(
  parameter int LINE_BEATS = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     icache_ren,
  input  logic [31:0]              icache_raddr,
  output logic                     icache_raccept,
  output logic                     icache_wen_fill,
  output logic [LINE_BEATS*32-1:0] icache_wfill,
  input  logic                     dcache_ren,
  input  logic [31:0]              dcache_raddr,
  output logic                     dcache_raccept,
  output logic                     dcache_wen_fill,
  output logic [LINE_BEATS*32-1:0] dcache_wfill,
  input  logic                     uncache_ren,
  input  logic [31:0]              uncache_addr,
  input  logic [1:0]               uncache_size,
  output logic                     uncache_accept,
  output logic [31:0]              uncache_rdata,
  output logic                     uncache_fin,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic                     rd_err
);

  localparam int         LINE_W   = LINE_BEATS * 32;
  localparam logic [3:0] FILL_LEN = 4'(LINE_BEATS - 1);
  localparam logic [1:0] SRC_I    = 2'd0;
  localparam logic [1:0] SRC_D    = 2'd1;
  localparam logic [1:0] SRC_U    = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [31:0]         addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [2:0]          beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         urdata_q, urdata_d;
  logic                err_q, err_d;
  logic [1:0]          starv_q, starv_d;
  logic                any_req;
  logic [1:0]          grant;
  logic                ar_hs;

  assign any_req = icache_ren | dcache_ren | uncache_ren;
  assign ar_hs   = arvalid & arready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    line_d     = line_q;
    urdata_d   = urdata_q;
    err_d      = err_q;
    starv_d    = starv_q;

    // Starvation guard overrides the fixed dcache > uncache > icache order.
    if (icache_ren && starv_q == 2'd2) grant = SRC_I;
    else if (dcache_ren)               grant = SRC_D;
    else if (uncache_ren)              grant = SRC_U;
    else                               grant = SRC_I;

    // A beat outside DATA is not accepted (rready low) but is still a protocol error.
    if (rvalid && state_q != S_DATA) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!icache_ren || grant == SRC_I) starv_d = 2'd0;
        else if (starv_q != 2'd2)          starv_d = starv_q + 2'd1;
        if (any_req) begin
          owner_d = grant;
          burst_d = 2'b01;
          state_d = S_ADDR;
          case (grant)
            SRC_D: begin
              addr_d = dcache_raddr & 32'hFFFF_FFE0;
              len_d  = FILL_LEN;
              size_d = 3'd2;
            end
            SRC_U: begin
              addr_d = uncache_addr;
              len_d  = 4'd0;
              size_d = {1'b0, uncache_size};
            end
            default: begin
              addr_d = icache_raddr & 32'hFFFF_FFE0;
              len_d  = FILL_LEN;
              size_d = 3'd2;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (rvalid) begin
          if (rresp != 2'b00 || rid != arid ||
              (rlast && {1'b0, beat_cnt_q} != len_q)) err_d = 1'b1;
          if (owner_q == SRC_U) urdata_d = rdata;
          else                  line_d[{beat_cnt_q, 5'b0} +: 32] = rdata;
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (rlast) state_d = S_DONE;
        end
      end
      S_DONE: begin
        beat_cnt_d = 3'd0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd0;
      addr_q     <= 32'd0;
      len_q      <= 4'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      beat_cnt_q <= 3'd0;
      line_q     <= '0;
      urdata_q   <= 32'd0;
      err_q      <= 1'b0;
      starv_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      line_q     <= line_d;
      urdata_q   <= urdata_d;
      err_q      <= err_d;
      starv_q    <= starv_d;
    end
  end

  assign arvalid         = (state_q == S_ADDR);
  assign rready          = (state_q == S_DATA);
  assign arid            = {2'b00, owner_q};
  assign araddr          = addr_q;
  assign arlen           = len_q;
  assign arsize          = size_q;
  assign arburst         = burst_q;
  assign arlock          = 2'b00;
  assign arcache         = 4'b0000;
  assign arprot          = 3'b000;
  assign icache_raccept  = ar_hs && (owner_q == SRC_I);
  assign dcache_raccept  = ar_hs && (owner_q == SRC_D);
  assign uncache_accept  = ar_hs && (owner_q == SRC_U);
  assign icache_wen_fill = (state_q == S_DONE) && (owner_q == SRC_I);
  assign dcache_wen_fill = (state_q == S_DONE) && (owner_q == SRC_D);
  assign uncache_fin     = (state_q == S_DONE) && (owner_q == SRC_U);
  // Single shared line buffer: only one fill can be outstanding.
  assign icache_wfill    = line_q;
  assign dcache_wfill    = line_q;
  assign uncache_rdata   = urdata_q;
  assign rd_err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_read_arbiter: directed self-checking bench for axi_read_arbiter.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axi_read_arbiter;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         icache_ren = 1'b0, dcache_ren = 1'b0, uncache_ren = 1'b0;
  logic [31:0]  icache_raddr = '0, dcache_raddr = '0, uncache_addr = '0;
  logic [1:0]   uncache_size = '0;
  logic         icache_raccept, icache_wen_fill, dcache_raccept, dcache_wen_fill;
  logic [255:0] icache_wfill, dcache_wfill;
  logic         uncache_accept, uncache_fin;
  logic [31:0]  uncache_rdata;
  logic [3:0]   arid, arlen, arcache;
  logic [31:0]  araddr;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, arlock;
  logic         arvalid, rready, rd_err;
  logic         arready = 1'b0;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0, rvalid = 1'b0;

  int errors = 0;
  int checks = 0;
  int n_iacc = 0, n_ifill = 0, n_dacc = 0, n_dfill = 0, n_fin = 0;

  axi_read_arbiter #(.LINE_BEATS(8)) dut (
    .clk(clk), .rstn(rstn),
    .icache_ren(icache_ren), .icache_raddr(icache_raddr), .icache_raccept(icache_raccept),
    .icache_wen_fill(icache_wen_fill), .icache_wfill(icache_wfill),
    .dcache_ren(dcache_ren), .dcache_raddr(dcache_raddr), .dcache_raccept(dcache_raccept),
    .dcache_wen_fill(dcache_wen_fill), .dcache_wfill(dcache_wfill),
    .uncache_ren(uncache_ren), .uncache_addr(uncache_addr), .uncache_size(uncache_size),
    .uncache_accept(uncache_accept), .uncache_rdata(uncache_rdata), .uncache_fin(uncache_fin),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (icache_raccept)  n_iacc++;
    if (icache_wen_fill) n_ifill++;
    if (dcache_raccept)  n_dacc++;
    if (dcache_wen_fill) n_dfill++;
    if (uncache_fin)     n_fin++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n R beats starting in the current DATA cycle; returns at the start of the cycle after the last beat.
  task automatic send_beats(input int n, input logic [31:0] base, input logic [3:0] id,
                            input int bad_resp, input int bad_id, input bit toggle, input bit last);
    for (int k = 0; k < n; k++) begin
      if (toggle) begin
        rvalid = 1'b0;
        step();
      end
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rid    = (k == bad_id) ? 4'd3 : id;
      rresp  = (k == bad_resp) ? 2'b10 : 2'b00;
      rlast  = last && (k == n - 1);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  // Serves one whole transaction with arready high; returns in the following IDLE cycle.
  task automatic serve(input bit drop_d, output logic [3:0] id);
    int waited = 0;
    arready = 1'b1;
    @(negedge clk);
    while (!arvalid && waited < 20) begin
      step();
      @(negedge clk);
      waited++;
    end
    chk("serve_arvalid", {255'd0, arvalid}, 256'd1);
    id = arid;
    if (arid == 4'd0) icache_ren = 1'b0;
    if (arid == 4'd2) uncache_ren = 1'b0;
    if (arid == 4'd1 && drop_d) dcache_ren = 1'b0;
    step();
    send_beats(int'(arlen) + 1, 32'hC0DE_0000, id, -1, -1, 1'b0, 1'b1);
    step();
  endtask

  logic [255:0] exp_line;
  logic [3:0]   gid;
  int           fills_before, fins_before;

  initial begin
    // Reset state
    step(); step(); step();
    @(negedge clk);
    chk("rst_arvalid", {255'd0, arvalid}, 256'd0);
    chk("rst_rready", {255'd0, rready}, 256'd0);
    chk("rst_araddr", {224'd0, araddr}, 256'd0);
    chk("rst_arid", {252'd0, arid}, 256'd0);
    chk("rst_wfill", dcache_wfill, 256'd0);
    chk("rst_urdata", {224'd0, uncache_rdata}, 256'd0);
    chk("rst_err", {255'd0, rd_err}, 256'd0);
    step();
    rstn = 1'b1;
    step();

    // dcache line fill, zero-wait slave
    dcache_ren = 1'b1; dcache_raddr = 32'h1FC0_0024; arready = 1'b1;
    @(negedge clk);
    chk("d_T_arvalid", {255'd0, arvalid}, 256'd0);
    step();
    dcache_ren = 1'b0;
    @(negedge clk);
    chk("d_araddr", {224'd0, araddr}, {224'd0, 32'h1FC0_0020});
    chk("d_arlen", {252'd0, arlen}, 256'd7);
    chk("d_arsize", {253'd0, arsize}, 256'd2);
    chk("d_arburst", {254'd0, arburst}, 256'd1);
    chk("d_arid", {252'd0, arid}, 256'd1);
    chk("d_fixed", {247'd0, arlock, arcache, arprot}, 256'd0);
    chk("d_accept", {255'd0, dcache_raccept}, 256'd1);
    step();
    @(negedge clk);
    chk("d_rready", {255'd0, rready}, 256'd1);
    chk("d_accept_gone", {255'd0, dcache_raccept}, 256'd0);
    send_beats(8, 32'h10, 4'd1, -1, -1, 1'b0, 1'b1);
    @(negedge clk);
    chk("d_wen_fill", {255'd0, dcache_wen_fill}, 256'd1);
    chk("d_wfill_lo", {224'd0, dcache_wfill[31:0]}, 256'h10);
    chk("d_wfill_hi", {224'd0, dcache_wfill[255:224]}, 256'h17);
    chk("d_err", {255'd0, rd_err}, 256'd0);
    step();
    @(negedge clk);
    chk("d_wen_gone", {255'd0, dcache_wen_fill}, 256'd0);

    // Uncached single-beat read
    uncache_ren = 1'b1; uncache_addr = 32'hBFAF_F002; uncache_size = 2'd1;
    step();
    uncache_ren = 1'b0;
    @(negedge clk);
    chk("u_araddr", {224'd0, araddr}, {224'd0, 32'hBFAF_F002});
    chk("u_arlen", {252'd0, arlen}, 256'd0);
    chk("u_arsize", {253'd0, arsize}, 256'd1);
    chk("u_arid", {252'd0, arid}, 256'd2);
    chk("u_accept", {255'd0, uncache_accept}, 256'd1);
    step();
    send_beats(1, 32'h0000_ABCD, 4'd2, -1, -1, 1'b0, 1'b1);
    @(negedge clk);
    chk("u_fin", {255'd0, uncache_fin}, 256'd1);
    chk("u_rdata", {224'd0, uncache_rdata}, 256'hABCD);
    step();
    @(negedge clk);
    chk("u_fin_gone", {255'd0, uncache_fin}, 256'd0);
    chk("u_rdata_held", {224'd0, uncache_rdata}, 256'hABCD);
    step();

    // Simultaneous requests: dcache, uncache, icache
    icache_ren = 1'b1; dcache_ren = 1'b1; uncache_ren = 1'b1;
    icache_raddr = 32'h0000_0100; dcache_raddr = 32'h0000_0200; uncache_addr = 32'h0000_0300;
    uncache_size = 2'd2;
    serve(1'b1, gid); chk("arb_1st", {252'd0, gid}, 256'd1);
    serve(1'b1, gid); chk("arb_2nd", {252'd0, gid}, 256'd2);
    serve(1'b1, gid); chk("arb_3rd", {252'd0, gid}, 256'd0);

    // Starvation guard: icache every third grant while dcache keeps requesting
    icache_ren = 1'b1; dcache_ren = 1'b1;
    for (int g = 0; g < 6; g++) begin
      serve(1'b0, gid);
      chk($sformatf("starv_%0d", g), {252'd0, gid}, (g % 3 == 2) ? 256'd0 : 256'd1);
      icache_ren = 1'b1;
    end
    icache_ren = 1'b0; dcache_ren = 1'b0;
    step(); step();

    // icache fill with arready delayed 5 cycles and rvalid every other cycle
    n_iacc = 0; n_ifill = 0;
    icache_ren = 1'b1; icache_raddr = 32'h0000_1234; arready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_arvalid_%0d", i), {255'd0, arvalid}, 256'd1);
      chk($sformatf("hold_araddr_%0d", i), {224'd0, araddr}, {224'd0, 32'h0000_1220});
      step();
    end
    arready = 1'b1; icache_ren = 1'b0;
    @(negedge clk);
    chk("i_accept", {255'd0, icache_raccept}, 256'd1);
    step();
    arready = 1'b0;
    send_beats(8, 32'h20, 4'd0, -1, -1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'h20 + 32'(k);
    @(negedge clk);
    chk("i_wen_fill", {255'd0, icache_wen_fill}, 256'd1);
    chk("i_wfill", icache_wfill, exp_line);
    step();
    chk("i_acc_count", 256'(n_iacc), 256'd1);
    chk("i_fill_count", 256'(n_ifill), 256'd1);

    // rresp error on beat 3
    arready = 1'b1; dcache_ren = 1'b1; dcache_raddr = 32'h0000_0040;
    step();
    dcache_ren = 1'b0;
    step();
    send_beats(8, 32'h30, 4'd1, 3, -1, 1'b0, 1'b1);
    @(negedge clk);
    chk("resp_err", {255'd0, rd_err}, 256'd1);
    chk("resp_fill", {255'd0, dcache_wen_fill}, 256'd1);
    step(); step();
    @(negedge clk);
    chk("err_sticky", {255'd0, rd_err}, 256'd0 | 256'd1);
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    @(negedge clk);
    chk("err_cleared", {255'd0, rd_err}, 256'd0);
    step();

    // rid error on beat 3
    dcache_ren = 1'b1;
    step();
    dcache_ren = 1'b0;
    step();
    send_beats(8, 32'h40, 4'd1, -1, 3, 1'b0, 1'b1);
    @(negedge clk);
    chk("rid_err", {255'd0, rd_err}, 256'd1);
    chk("rid_fill", {255'd0, dcache_wen_fill}, 256'd1);
    step();

    // Reset in the middle of a fill
    dcache_ren = 1'b1; dcache_raddr = 32'h0000_0080;
    step();
    dcache_ren = 1'b0;
    step();
    send_beats(4, 32'h50, 4'd1, -1, -1, 1'b0, 1'b0);
    fills_before = n_dfill;
    rstn = 1'b0;
    step();
    @(negedge clk);
    chk("mid_arvalid", {255'd0, arvalid}, 256'd0);
    chk("mid_rready", {255'd0, rready}, 256'd0);
    chk("mid_wen", {255'd0, dcache_wen_fill}, 256'd0);
    chk("mid_wfill", dcache_wfill, 256'd0);
    chk("mid_urdata", {224'd0, uncache_rdata}, 256'd0);
    chk("mid_err", {255'd0, rd_err}, 256'd0);
    chk("mid_araddr", {224'd0, araddr}, 256'd0);
    step();
    rstn = 1'b1;
    step(); step();
    chk("mid_no_fill", 256'(n_dfill), 256'(fills_before));
    fins_before = n_fin;
    uncache_ren = 1'b1; uncache_addr = 32'h0000_0010; uncache_size = 2'd2;
    serve(1'b1, gid);
    chk("post_rst_id", {252'd0, gid}, 256'd2);
    chk("post_rst_fin", 256'(n_fin), 256'(fins_before + 1));
    chk("post_rst_rdata", {224'd0, uncache_rdata}, {224'd0, 32'hC0DE_0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
